// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//
// Hazard block for a 5-stage MIPS pipeline. It combines two functions:
//   * EX-stage operand forwarding: F1/F2 pick the ALU operand source
//     (10 = EX/MEM result, 01 = MEM/WB result, 00 = register file).
//   * Load-use hazard detection in decode. A RUN/HOLD stall FSM holds PC and
//     IF/ID and bubbles ID/EX for LOAD_LAT consecutive cycles per hazard.
//
// Handshake: there is no valid/ready pair. PC_Write/IF_ID_Write are
// active-high "may update" enables and ID_EX_Flush is an active-high bubble
// request. All three are driven on the same cycle as the stall decision.
//
// Optional feature: define HAZ_STATS_EN to build saturating stall and
// forwarding counters. Without it, stall_cnt and fwd_cnt are tied to zero
// and no counter registers exist.
//
// Parameters:
//   REG_AW   register-address width
//   LOAD_LAT load-use stall length in cycles (1..15)
//   CNT_W    statistics counter width
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   IF_ID_rs/rt, IF_ID_use_rs/rt  source registers read by the decode instruction
//   ID_EX_rs/rt/rd, ID_EX_MemRead EX-stage operands, destination and load flag
//   EX_MEM_rd/RegWrite            MEM-stage destination and write enable
//   MEM_WB_rd/RegWrite            WB-stage destination and write enable
//   F1, F2                        ALU operand A/B forwarding selects
//   PC_Write, IF_ID_Write         update enables (low while stalling)
//   ID_EX_Flush                   bubble request (high while stalling)
//   stall_cnt, fwd_cnt            statistics counters (zero unless HAZ_STATS_EN)
//   dbg_state_o                   stall FSM state (0 = RUN, 1 = HOLD)
module hazard_forward_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] IF_ID_rs,
    input  logic [REG_AW-1:0] IF_ID_rt,
    input  logic              IF_ID_use_rs,
    input  logic              IF_ID_use_rt,
    input  logic [REG_AW-1:0] ID_EX_rs,
    input  logic [REG_AW-1:0] ID_EX_rt,
    input  logic [REG_AW-1:0] ID_EX_rd,
    input  logic              ID_EX_MemRead,
    input  logic [REG_AW-1:0] EX_MEM_rd,
    input  logic              EX_MEM_RegWrite,
    input  logic [REG_AW-1:0] MEM_WB_rd,
    input  logic              MEM_WB_RegWrite,
    output logic [1:0]        F1,
    output logic [1:0]        F2,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              ID_EX_Flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic              dbg_state_o
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Cycles still to be spent in HOLD after the stall's first (RUN) cycle.
    localparam logic [3:0] REM_INIT = 4'(LOAD_LAT - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic [1:0] f1_raw, f2_raw;
    logic       haz;
    logic       stall_raw;
    logic       stall;

    // Forwarding selects. EX/MEM is the younger result, so it wins when
    // both stages write the same register. Register 0 is never forwarded.
    always_comb begin
        f1_raw = 2'b00;
        if (EX_MEM_RegWrite && (EX_MEM_rd != '0) && (EX_MEM_rd == ID_EX_rs)) begin
            f1_raw = 2'b10;
        end else if (MEM_WB_RegWrite && (MEM_WB_rd != '0) && (MEM_WB_rd == ID_EX_rs)) begin
            f1_raw = 2'b01;
        end
    end

    always_comb begin
        f2_raw = 2'b00;
        if (EX_MEM_RegWrite && (EX_MEM_rd != '0) && (EX_MEM_rd == ID_EX_rt)) begin
            f2_raw = 2'b10;
        end else if (MEM_WB_RegWrite && (MEM_WB_rd != '0) && (MEM_WB_rd == ID_EX_rt)) begin
            f2_raw = 2'b01;
        end
    end

    // Load in EX whose destination is read by the instruction in decode.
    assign haz = ID_EX_MemRead && (ID_EX_rd != '0) &&
                 ((IF_ID_use_rs && (ID_EX_rd == IF_ID_rs)) ||
                  (IF_ID_use_rt && (ID_EX_rd == IF_ID_rt)));

    // The first stall cycle is spent in RUN. HOLD covers the remaining
    // LOAD_LAT-1 cycles and ignores haz. HOLD returns to RUN with no gap, so
    // a hazard still present then starts a new stall on the very next cycle.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        stall_raw = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall_raw = haz;
                if (haz && (LOAD_LAT > 1)) begin
                    state_d = ST_HOLD;
                    rem_d   = REM_INIT;
                end
            end
            ST_HOLD: begin
                stall_raw = 1'b1;
                rem_d     = rem_q - 4'd1;
                if (rem_q == 4'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                rem_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // While reset is high the pipeline sees a quiet unit: no stall and no
    // forwarding.
    assign stall       = stall_raw && !reset;
    assign F1          = reset ? 2'b00 : f1_raw;
    assign F2          = reset ? 2'b00 : f2_raw;
    assign PC_Write    = !stall;
    assign IF_ID_Write = !stall;
    assign ID_EX_Flush = stall;
    assign dbg_state_o = state_q;

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (((F1 != 2'b00) || (F2 != 2'b00)) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule
